// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB sizing and instruction-kind encodings
package reorder_buffer_pkg;
    localparam int ROB_SIZE_LOG_DEF = 4;
    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_RSVD   = 2'd3
    } rob_kind_e;
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with tag-indexed result broadcast and branch flush
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE_LOG = ROB_SIZE_LOG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    issue_valid,
    input  logic [1:0]              issue_kind,
    input  logic [4:0]              issue_rd,
    output logic [ROB_SIZE_LOG-1:0] next_robid,
    output logic                    rob_full,
    input  logic [ROB_SIZE_LOG-1:0] rs1_query,
    output logic                    rs1_ready,
    output logic [31:0]             rs1_value,
    input  logic [ROB_SIZE_LOG-1:0] rs2_query,
    output logic                    rs2_ready,
    output logic [31:0]             rs2_value,
    input  logic                    alu_valid,
    input  logic [ROB_SIZE_LOG-1:0] alu_robid,
    input  logic [31:0]             alu_value,
    input  logic                    alu_mispredict,
    input  logic                    slb_valid,
    input  logic [ROB_SIZE_LOG-1:0] slb_robid,
    input  logic [31:0]             slb_value,
    output logic                    commit_valid,
    output logic [ROB_SIZE_LOG-1:0] commit_robid,
    output logic [4:0]              commit_rd,
    output logic [31:0]             commit_value,
    output logic                    store_commit,
    output logic                    flush,
    output logic [31:0]             flush_pc
);
    localparam int ROB_SIZE = 2 ** ROB_SIZE_LOG;
    logic [ROB_SIZE-1:0]     busy, ready, mispredict;
    rob_kind_e               kind  [ROB_SIZE];
    logic [4:0]              rd    [ROB_SIZE];
    logic [31:0]             value [ROB_SIZE];
    logic [ROB_SIZE_LOG-1:0] head, tail;
    logic [ROB_SIZE_LOG:0]   count;
    logic                    accept, retire, do_flush;
    rob_kind_e               kind_in;
    assign next_robid = tail;
    assign rob_full   = count == (ROB_SIZE_LOG+1)'(ROB_SIZE);
    assign accept     = rdy && issue_valid && !rob_full;
    assign retire     = rdy && count != '0 && ready[head];
    assign do_flush   = retire && kind[head] == KIND_BRANCH && mispredict[head];
    assign kind_in    = issue_kind == KIND_RSVD ? KIND_REG : rob_kind_e'(issue_kind);
    assign rs1_ready  = busy[rs1_query] && ready[rs1_query];
    assign rs1_value  = value[rs1_query];
    assign rs2_ready  = busy[rs2_query] && ready[rs2_query];
    assign rs2_value  = value[rs2_query];
    always_ff @(posedge clk) begin
        if (!rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            ready        <= '0;
            mispredict   <= '0;
            commit_valid <= 1'b0;
            commit_robid <= '0;
            commit_rd    <= '0;
            commit_value <= '0;
            store_commit <= 1'b0;
            flush        <= 1'b0;
            flush_pc     <= '0;
        end else begin
            commit_valid <= retire && kind[head] == KIND_REG;
            store_commit <= retire && kind[head] == KIND_STORE;
            flush        <= do_flush;
            if (retire) begin
                commit_robid <= head;
                commit_rd    <= rd[head];
                commit_value <= value[head];
            end
            // a retiring mispredict squashes everything, including this edge's issue and broadcasts
            if (do_flush) begin
                flush_pc   <= value[head];
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                busy       <= '0;
                ready      <= '0;
                mispredict <= '0;
            end else if (rdy) begin
                if (alu_valid) begin
                    ready[alu_robid]      <= 1'b1;
                    value[alu_robid]      <= alu_value;
                    mispredict[alu_robid] <= alu_mispredict;
                end
                if (slb_valid) begin
                    ready[slb_robid] <= 1'b1;
                    value[slb_robid] <= slb_value;
                end
                if (accept) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    mispredict[tail] <= 1'b0;
                    kind[tail]       <= kind_in;
                    rd[tail]         <= issue_rd;
                    tail             <= tail + 1'b1;
                end
                if (retire) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + 1'b1;
                end
                count <= count + {{ROB_SIZE_LOG{1'b0}}, accept} - {{ROB_SIZE_LOG{1'b0}}, retire};
            end
        end
    end
endmodule
